// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S mono transmitter; requests one DDS sample per frame and sends
//            it MSB first in both channels with the standard one-bclk delay.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int DATA_WDTH = 24,
    parameter int BCLK_HALF = 2,
    parameter int SINE_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 query_sine,
    input  logic [DATA_WDTH-1:0] sine,
    output logic                 bclk,
    output logic                 lrclk,
    output logic                 sdata
);

    localparam int         c_DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int         c_LAT_W      = $clog2(SINE_LAT + 1);
    localparam logic [5:0] c_QUERY_SLOT = 6'd60;

    logic [c_DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic                 bclk_q, bclk_d;
    logic [5:0]           slot_q, slot_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic [DATA_WDTH-1:0] shift_q, shift_d;
    logic [DATA_WDTH-1:0] hold_q, hold_d;
    logic                 query_q, query_d;
    logic                 pend_q, pend_d;
    logic [c_LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

    logic                 w_wrap;
    logic                 w_fall;
    logic                 w_capture;
    logic [5:0]           w_slot_nxt;
    logic [31:0]          w_word;

    always_comb begin
        w_wrap     = en && (div_cnt_q == c_DIV_W'(BCLK_HALF - 1));
        w_fall     = w_wrap && bclk_q;
        w_slot_nxt = slot_q + 6'd1;
        w_capture  = pend_q && (lat_cnt_q == c_LAT_W'(SINE_LAT));
        // Bit 31 is the delay slot (always 0), sample MSB sits at bit 30.
        w_word     = '0;
        w_word[30 -: DATA_WDTH] = shift_q;

        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        slot_d    = slot_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        query_d   = 1'b0;
        pend_d    = pend_q;
        lat_cnt_d = lat_cnt_q;

        if (en) begin
            div_cnt_d = w_wrap ? '0 : div_cnt_q + c_DIV_W'(1);
        end
        if (w_wrap) begin
            bclk_d = ~bclk_q;
        end

        if (w_fall) begin
            slot_d  = w_slot_nxt;
            lrclk_d = w_slot_nxt[5];
            sdata_d = w_word[5'd31 - w_slot_nxt[4:0]];
            // At the longest latency the capture lands on this same edge.
            if (w_slot_nxt[4:0] == 5'd0) begin
                shift_d = w_capture ? sine : hold_q;
            end
            if ((w_slot_nxt == c_QUERY_SLOT) && !pend_q) begin
                query_d = 1'b1;
            end
        end

        if (w_capture) begin
            hold_d = sine;
            pend_d = 1'b0;
        end else if (pend_q) begin
            lat_cnt_d = lat_cnt_q + c_LAT_W'(1);
        end
        if (query_q) begin
            pend_d    = 1'b1;
            lat_cnt_d = c_LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            slot_q    <= '0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            shift_q   <= '0;
            hold_q    <= '0;
            query_q   <= 1'b0;
            pend_q    <= 1'b0;
            lat_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            slot_q    <= slot_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            query_q   <= query_d;
            pend_q    <= pend_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign query_sine = query_q;
    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;

endmodule
`default_nettype wire
